// File: rtl/mig_rw_scheduler_if.sv
// Command-port handshake bundle between the AXIS adapters, the MIG UI and the
// read/write scheduler. The scheduler uses the master view; the environment uses slave.
interface mig_rw_scheduler_if #(
    parameter int MAX_OUTSTANDING = 8
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic          init_calib_complete;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic          app_rd_data_valid;
    logic          wr_req_valid;
    logic          rd_req_valid;
    logic          rd_fifo_af;
    logic          grant_wr;
    logic          grant_rd;
    logic [OW-1:0] rd_outstanding;
    logic          err_underflow;
    logic [31:0]   perf_rd_cmds;
    logic [31:0]   perf_wr_cmds;
    logic [31:0]   perf_turns;

    modport master (
        input  init_calib_complete,
        input  app_rdy,
        input  app_wdf_rdy,
        input  app_rd_data_valid,
        input  wr_req_valid,
        input  rd_req_valid,
        input  rd_fifo_af,
        output grant_wr,
        output grant_rd,
        output rd_outstanding,
        output err_underflow,
        output perf_rd_cmds,
        output perf_wr_cmds,
        output perf_turns
    );

    modport slave (
        output init_calib_complete,
        output app_rdy,
        output app_wdf_rdy,
        output app_rd_data_valid,
        output wr_req_valid,
        output rd_req_valid,
        output rd_fifo_af,
        input  grant_wr,
        input  grant_rd,
        input  rd_outstanding,
        input  err_underflow,
        input  perf_rd_cmds,
        input  perf_wr_cmds,
        input  perf_turns
    );
endinterface

// File: rtl/mig_rw_scheduler.sv
// Read/write sequencer for the single MIG UI command port: bounded bursts, read credits,
// FIFO almost-full guard and turnaround bubble. Define MIG_RW_SCHED_PERF_EN for perf counters.
module mig_rw_scheduler #(
    parameter int RD_BURST_MAX    = 16,
    parameter int WR_BURST_MAX    = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TURN_CYCLES     = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    mig_rw_scheduler_if.master bus
);

    localparam logic [1:0] ST_CALIB = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int RBW       = $clog2(RD_BURST_MAX + 1);
    localparam int WBW       = $clog2(WR_BURST_MAX + 1);
    localparam int TW        = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int TURN_LAST = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

    localparam logic [OW-1:0]  OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [RBW-1:0] RD_MAX   = RBW'(RD_BURST_MAX);
    localparam logic [WBW-1:0] WR_MAX   = WBW'(WR_BURST_MAX);
    localparam logic [TW-1:0]  TURN_END = TW'(TURN_LAST);

    logic [1:0]     state_q, state_d;
    logic [1:0]     target_q, target_d;
    logic [TW-1:0]  turn_cnt_q, turn_cnt_d;
    logic [RBW-1:0] rd_burst_q, rd_burst_d;
    logic [WBW-1:0] wr_burst_q, wr_burst_d;
    logic [OW-1:0]  rd_outstanding_q, rd_outstanding_d;
    logic           err_underflow_q, err_underflow_d;

    logic           rd_ok;
    logic           grant_rd;
    logic           grant_wr;
    logic           rd_fire;
    logic           wr_fire;
    logic [RBW-1:0] rd_burst_inc;
    logic [WBW-1:0] wr_burst_inc;
    logic           rd_burst_done;
    logic           wr_burst_done;

    always_comb begin
        rd_ok    = bus.rd_req_valid && (rd_outstanding_q < OUT_MAX) && !bus.rd_fifo_af;
        grant_rd = (state_q == ST_RD) && rd_ok;
        grant_wr = (state_q == ST_WR);
        rd_fire  = grant_rd && bus.app_rdy;
        wr_fire  = grant_wr && bus.wr_req_valid && bus.app_rdy && bus.app_wdf_rdy;

        // Burst limits look at the count including this cycle's fire, so the
        // phase ends on exactly the last permitted command.
        rd_burst_inc  = rd_burst_q + RBW'(rd_fire);
        wr_burst_inc  = wr_burst_q + WBW'(wr_fire);
        rd_burst_done = (rd_burst_inc == RD_MAX);
        wr_burst_done = (wr_burst_inc == WR_MAX);
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        turn_cnt_d = turn_cnt_q;
        rd_burst_d = rd_burst_q;
        wr_burst_d = wr_burst_q;

        case (state_q)
            ST_CALIB: begin
                if (bus.init_calib_complete) begin
                    state_d    = ST_RD;
                    rd_burst_d = '0;
                end
            end

            ST_RD: begin
                rd_burst_d = rd_burst_inc;
                if (bus.wr_req_valid && (rd_burst_done || !rd_ok)) begin
                    rd_burst_d = '0;
                    wr_burst_d = '0;
                    if (TURN_CYCLES > 0) begin
                        state_d    = ST_TURN;
                        target_d   = ST_WR;
                        turn_cnt_d = '0;
                    end else begin
                        state_d = ST_WR;
                    end
                end else if (rd_burst_done) begin
                    rd_burst_d = '0;
                end
            end

            ST_WR: begin
                wr_burst_d = wr_burst_inc;
                if (rd_ok && (wr_burst_done || !bus.wr_req_valid)) begin
                    wr_burst_d = '0;
                    rd_burst_d = '0;
                    if (TURN_CYCLES > 0) begin
                        state_d    = ST_TURN;
                        target_d   = ST_RD;
                        turn_cnt_d = '0;
                    end else begin
                        state_d = ST_RD;
                    end
                end else if (wr_burst_done) begin
                    wr_burst_d = '0;
                end
            end

            ST_TURN: begin
                if (turn_cnt_q == TURN_END) begin
                    state_d    = target_q;
                    turn_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_CALIB;
            end
        endcase
    end

    // A data beat with nothing in flight means the MIG and our view disagree;
    // hold at zero and latch the error rather than wrapping.
    always_comb begin
        rd_outstanding_d = rd_outstanding_q;
        err_underflow_d  = err_underflow_q;
        case ({rd_fire, bus.app_rd_data_valid})
            2'b10: rd_outstanding_d = rd_outstanding_q + 1'b1;
            2'b01: begin
                if (rd_outstanding_q == '0) begin
                    err_underflow_d = 1'b1;
                end else begin
                    rd_outstanding_d = rd_outstanding_q - 1'b1;
                end
            end
            default: begin
                rd_outstanding_d = rd_outstanding_q;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= ST_CALIB;
            target_q         <= ST_RD;
            turn_cnt_q       <= '0;
            rd_burst_q       <= '0;
            wr_burst_q       <= '0;
            rd_outstanding_q <= '0;
            err_underflow_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            turn_cnt_q       <= turn_cnt_d;
            rd_burst_q       <= rd_burst_d;
            wr_burst_q       <= wr_burst_d;
            rd_outstanding_q <= rd_outstanding_d;
            err_underflow_q  <= err_underflow_d;
        end
    end

    assign bus.grant_rd       = grant_rd;
    assign bus.grant_wr       = grant_wr;
    assign bus.rd_outstanding = rd_outstanding_q;
    assign bus.err_underflow  = err_underflow_q;

`ifdef MIG_RW_SCHED_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_turns_q, perf_turns_d;
    logic        dir_change;

    // A direction change is either entry into the bubble or, with no bubble,
    // a direct hop between the two data phases.
    always_comb begin
        dir_change = ((state_q != ST_TURN) && (state_d == ST_TURN)) ||
                     ((state_q == ST_RD) && (state_d == ST_WR)) ||
                     ((state_q == ST_WR) && (state_d == ST_RD));

        perf_rd_d    = perf_rd_q;
        perf_wr_d    = perf_wr_q;
        perf_turns_d = perf_turns_q;
        if (rd_fire && (perf_rd_q != 32'hFFFF_FFFF)) begin
            perf_rd_d = perf_rd_q + 32'd1;
        end
        if (wr_fire && (perf_wr_q != 32'hFFFF_FFFF)) begin
            perf_wr_d = perf_wr_q + 32'd1;
        end
        if (dir_change && (perf_turns_q != 32'hFFFF_FFFF)) begin
            perf_turns_d = perf_turns_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_turns_q <= '0;
        end else begin
            perf_rd_q    <= perf_rd_d;
            perf_wr_q    <= perf_wr_d;
            perf_turns_q <= perf_turns_d;
        end
    end

    assign bus.perf_rd_cmds = perf_rd_q;
    assign bus.perf_wr_cmds = perf_wr_q;
    assign bus.perf_turns   = perf_turns_q;
`else
    assign bus.perf_rd_cmds = '0;
    assign bus.perf_wr_cmds = '0;
    assign bus.perf_turns   = '0;
`endif

endmodule
